// File: rtl/gb_arb_pkg.sv
// Shared types and constants for the ghostbus arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gb_arb_pkg;

    // Default ghostbus geometry.
    localparam int GB_AW = 24;
    localparam int GB_DW = 32;

    // Requester index width covers the legal NREQ range of 2..4.
    localparam int IDX_W = 2;
    // Read-delay counter width; RD_DELAY tops out at 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } gb_state_t;

endpackage

// File: rtl/gb_arbiter_if.sv
// Bundle of requester handshake and ghostbus signals for gb_arbiter.
// Latency: n/a (wires only); slave = arbiter view, master = environment view.
// Backpressure: req_ready is the only accept indication; one transaction in flight.
interface gb_arbiter_if
    import gb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = GB_AW,
    parameter int DW   = GB_DW
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [AW-1:0]      gb_addr;
    logic [DW-1:0]      gb_wdata;
    logic               gb_wen;
    logic               gb_rstb;
    logic [DW-1:0]      gb_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, gb_rdata,
        output req_ready, rsp_valid, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, gb_rdata,
        input  req_ready, rsp_valid, rsp_rdata, gb_addr, gb_wdata, gb_wen, gb_rstb
    );
endinterface

// File: rtl/gb_rr_pick.sv
// Round-robin winner select: i_req vector, i_last grant -> o_idx winner, o_any.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module gb_rr_pick
    import gb_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk candidates from farthest (last grant itself) to nearest
    // (last grant + 1); the final hit is the highest-priority requester.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (i_req[j] && (j == ((int'(i_last) + k) % NREQ))) begin
                    o_idx = j[IDX_W-1:0];
                    o_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gb_arbiter.sv
// Round-robin arbiter of NREQ requesters onto a single ghostbus master port.
// Latency: write accept->rsp_valid 2 cycles, read RD_DELAY+2; strobes are one cycle.
// Backpressure: req_ready pulses only in IDLE; one transaction outstanding at a time.
// Ports: gb_clk/gb_rst_n (async active-low); bus = requester side + ghostbus side.
module gb_arbiter
    import gb_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = GB_AW,
    parameter int DW       = GB_DW,
    parameter int RD_DELAY = 1
) (
    input  logic         gb_clk,
    input  logic         gb_rst_n,
    gb_arbiter_if.slave  bus
);

    gb_state_t          r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_idx;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_armed;
    logic [AW-1:0]      r_gb_addr;
    logic [DW-1:0]      r_gb_wdata;
    logic               r_gb_wen;
    logic               r_gb_rstb;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [DW-1:0]      r_rsp_rdata;

    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic [NREQ-1:0]    w_win_oh;
    logic [NREQ-1:0]    w_rsp_oh;
    logic               w_sel_we;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_wdata;
    logic               w_accept;

    gb_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req  (bus.req_valid),
        .i_last (r_last),
        .o_idx  (w_win_idx),
        .o_any  (w_win_any)
    );

    // Demux the winner's fields out of the flattened request buses and
    // build the one-hot masks for the grant and the response.
    always_comb begin
        w_win_oh    = '0;
        w_rsp_oh    = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win_idx == j[IDX_W-1:0]) begin
                w_win_oh[j] = 1'b1;
                w_sel_we    = bus.req_we[j];
                w_sel_addr  = bus.req_addr[j*AW +: AW];
                w_sel_wdata = bus.req_wdata[j*DW +: DW];
            end
            w_rsp_oh[j] = (r_idx == j[IDX_W-1:0]);
        end
    end

    // r_armed holds off grants on the first edge after reset release, so
    // nothing is accepted while reset is still being deasserted.
    assign w_accept = (r_state == ST_IDLE) && r_armed && w_win_any;

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_W'(NREQ - 1);
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_gb_addr   <= '0;
            r_gb_wdata  <= '0;
            r_gb_wen    <= 1'b0;
            r_gb_rstb   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_armed     <= 1'b1;
            // Strobes and completion are single-cycle pulses by default.
            r_gb_wen    <= 1'b0;
            r_gb_rstb   <= 1'b0;
            r_rsp_valid <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_idx      <= w_win_idx;
                        r_last     <= w_win_idx;
                        r_we       <= w_sel_we;
                        r_gb_addr  <= w_sel_addr;
                        r_gb_wdata <= w_sel_wdata;
                        r_gb_wen   <= w_sel_we;
                        r_gb_rstb  <= ~w_sel_we;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_we) begin
                        r_rsp_valid <= w_rsp_oh;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt   <= CNT_W'(RD_DELAY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= bus.gb_rdata;
                        r_rsp_valid <= w_rsp_oh;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_accept ? w_win_oh : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.gb_addr   = r_gb_addr;
    assign bus.gb_wdata  = r_gb_wdata;
    assign bus.gb_wen    = r_gb_wen;
    assign bus.gb_rstb   = r_gb_rstb;

endmodule

// File: tb/tb_gb_arbiter.sv
// Directed bench for gb_arbiter: one instance with RD_DELAY=1, one with RD_DELAY=8.
// Latency: expectations are cycle-exact relative to the observed accept cycle.
// Backpressure: the bench plays both requesters and the ghostbus slave.
module tb_gb_arbiter;

    logic gb_clk;
    logic gb_rst_n;
    int   n_cmp;
    int   n_err;

    gb_arbiter_if #(.NREQ(2), .AW(24), .DW(32)) ifa ();
    gb_arbiter_if #(.NREQ(2), .AW(24), .DW(32)) ifb ();

    gb_arbiter #(.NREQ(2), .AW(24), .DW(32), .RD_DELAY(1)) u_dut_a (
        .gb_clk   (gb_clk),
        .gb_rst_n (gb_rst_n),
        .bus      (ifa)
    );

    gb_arbiter #(.NREQ(2), .AW(24), .DW(32), .RD_DELAY(8)) u_dut_b (
        .gb_clk   (gb_clk),
        .gb_rst_n (gb_rst_n),
        .bus      (ifb)
    );

    initial gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;

    task automatic tick();
        @(posedge gb_clk);
        #2;
    endtask

    task automatic wait_rdy_a(input logic [1:0] mask, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((ifa.req_ready & mask) != 2'b00) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_rdy_b(input logic [1:0] mask, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if ((ifb.req_ready & mask) != 2'b00) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        gb_rst_n = 1'b1;
        #1;
        gb_rst_n = 1'b0;
        #1;
        n_cmp++; if (ifa.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b want 00", ifa.req_ready); end
        n_cmp++; if (ifa.rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", ifa.rsp_valid); end
        n_cmp++; if (ifa.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", ifa.rsp_rdata); end
        n_cmp++; if (ifa.gb_addr !== 24'h0) begin n_err++; $display("FAIL rst_gb_addr: got %h want 0", ifa.gb_addr); end
        n_cmp++; if (ifa.gb_wdata !== 32'h0) begin n_err++; $display("FAIL rst_gb_wdata: got %h want 0", ifa.gb_wdata); end
        n_cmp++; if (ifa.gb_wen !== 1'b0 || ifa.gb_rstb !== 1'b0) begin n_err++; $display("FAIL rst_strobes: got wen=%b rstb=%b want 0/0", ifa.gb_wen, ifa.gb_rstb); end
        n_cmp++; if (ifb.gb_rstb !== 1'b0 || ifb.gb_addr !== 24'h0) begin n_err++; $display("FAIL rst_b_outputs: got rstb=%b addr=%h want 0/0", ifb.gb_rstb, ifb.gb_addr); end
        tick();
        tick();
        gb_rst_n = 1'b1;
        #1;
    endtask

    // Single write from requester 0.
    task automatic test_write();
        bit ok;
        ifa.req_we[0]          = 1'b1;
        ifa.req_addr[23:0]     = 24'h000001;
        ifa.req_wdata[31:0]    = 32'h0000000E;
        ifa.req_valid          = 2'b01;
        #1;
        wait_rdy_a(2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wr_accept: got no req_ready want req_ready[0] within 40 cycles"); end
        n_cmp++; if (ifa.req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready_onehot: got %b want 01", ifa.req_ready); end
        tick();
        ifa.req_valid = 2'b00;
        #1;
        n_cmp++; if (ifa.gb_wen !== 1'b1 || ifa.gb_rstb !== 1'b0) begin n_err++; $display("FAIL wr_issue_strobes: got wen=%b rstb=%b want 1/0", ifa.gb_wen, ifa.gb_rstb); end
        n_cmp++; if (ifa.gb_addr !== 24'h000001) begin n_err++; $display("FAIL wr_issue_addr: got %h want 000001", ifa.gb_addr); end
        n_cmp++; if (ifa.gb_wdata !== 32'h0000000E) begin n_err++; $display("FAIL wr_issue_wdata: got %h want 0000000e", ifa.gb_wdata); end
        n_cmp++; if (ifa.rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_early_rsp: got %b want 00", ifa.rsp_valid); end
        tick();
        n_cmp++; if (ifa.rsp_valid !== 2'b01) begin n_err++; $display("FAIL wr_rsp_valid: got %b want 01", ifa.rsp_valid); end
        n_cmp++; if (ifa.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h want 0", ifa.rsp_rdata); end
        n_cmp++; if (ifa.gb_wen !== 1'b0 || ifa.gb_addr !== 24'h000001) begin n_err++; $display("FAIL wr_after_issue: got wen=%b addr=%h want 0/000001", ifa.gb_wen, ifa.gb_addr); end
        tick();
        n_cmp++; if (ifa.rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_rsp_pulse: got %b want 00", ifa.rsp_valid); end
    endtask

    // Read from requester 1 with RD_DELAY=1.
    task automatic test_read();
        bit ok;
        ifa.gb_rdata        = 32'h00000011;
        ifa.req_we[1]       = 1'b0;
        ifa.req_addr[47:24] = 24'h000000;
        ifa.req_valid       = 2'b10;
        #1;
        wait_rdy_a(2'b10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_accept: got no req_ready want req_ready[1] within 40 cycles"); end
        n_cmp++; if (ifa.req_ready !== 2'b10) begin n_err++; $display("FAIL rd_ready_onehot: got %b want 10", ifa.req_ready); end
        tick();
        ifa.req_valid = 2'b00;
        #1;
        n_cmp++; if (ifa.gb_rstb !== 1'b1 || ifa.gb_wen !== 1'b0) begin n_err++; $display("FAIL rd_issue_strobes: got rstb=%b wen=%b want 1/0", ifa.gb_rstb, ifa.gb_wen); end
        n_cmp++; if (ifa.gb_addr !== 24'h000000) begin n_err++; $display("FAIL rd_issue_addr: got %h want 000000", ifa.gb_addr); end
        tick();
        ifa.gb_rdata = 32'h00000042;
        #1;
        n_cmp++; if (ifa.rsp_valid !== 2'b00 || ifa.gb_rstb !== 1'b0) begin n_err++; $display("FAIL rd_wait_cycle: got rsp=%b rstb=%b want 00/0", ifa.rsp_valid, ifa.gb_rstb); end
        tick();
        ifa.gb_rdata = 32'h0000DEAD;
        #1;
        n_cmp++; if (ifa.rsp_valid !== 2'b10) begin n_err++; $display("FAIL rd_rsp_valid: got %b want 10", ifa.rsp_valid); end
        n_cmp++; if (ifa.rsp_rdata !== 32'h00000042) begin n_err++; $display("FAIL rd_rsp_rdata: got %h want 00000042", ifa.rsp_rdata); end
        tick();
        n_cmp++; if (ifa.rsp_valid !== 2'b00 || ifa.rsp_rdata !== 32'h00000042) begin n_err++; $display("FAIL rd_rdata_hold: got rsp=%b rdata=%h want 00/00000042", ifa.rsp_valid, ifa.rsp_rdata); end
    endtask

    // Both requesters hold requests; grants must alternate starting at 0.
    task automatic test_rr();
        bit ok;
        logic [1:0] exp_seq [4];
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        ifa.req_we          = 2'b11;
        ifa.req_addr[23:0]  = 24'h000010;
        ifa.req_addr[47:24] = 24'h000020;
        ifa.req_valid       = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            wait_rdy_a(2'b11, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_accept_%0d: got no req_ready want a grant within 40 cycles", g); end
            n_cmp++; if (ifa.req_ready !== exp_seq[g]) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", g, ifa.req_ready, exp_seq[g]); end
            tick();
        end
        ifa.req_valid = 2'b00;
        tick();
        tick();
        tick();
    endtask

    // RD_DELAY=8 read: data sampled 8 cycles after the strobe; requester 1
    // waits throughout and must not be accepted before the response.
    task automatic test_long_read();
        bit ok;
        int bad;
        ifb.gb_rdata        = 32'h0;
        ifb.req_we          = 2'b10;
        ifb.req_addr[23:0]  = 24'h000100;
        ifb.req_addr[47:24] = 24'h000077;
        ifb.req_wdata       = '0;
        ifb.req_valid       = 2'b01;
        #1;
        wait_rdy_b(2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL lr_accept: got no req_ready want req_ready[0] within 40 cycles"); end
        tick();
        ifb.req_valid = 2'b10;
        #1;
        n_cmp++; if (ifb.gb_rstb !== 1'b1 || ifb.gb_addr !== 24'h000100) begin n_err++; $display("FAIL lr_issue: got rstb=%b addr=%h want 1/000100", ifb.gb_rstb, ifb.gb_addr); end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ifb.gb_rdata = 32'h000000A0 + 32'(k);
            #1;
            if (ifb.gb_rstb !== 1'b0 || ifb.gb_wen !== 1'b0 || ifb.req_ready !== 2'b00 || ifb.rsp_valid !== 2'b00) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lr_wait_quiet: got %0d noisy cycles want 0", bad); end
        tick();
        n_cmp++; if (ifb.rsp_valid !== 2'b01) begin n_err++; $display("FAIL lr_rsp_valid: got %b want 01", ifb.rsp_valid); end
        n_cmp++; if (ifb.rsp_rdata !== 32'h000000A7) begin n_err++; $display("FAIL lr_rsp_rdata: got %h want 000000a7", ifb.rsp_rdata); end
        n_cmp++; if (ifb.req_ready !== 2'b00) begin n_err++; $display("FAIL lr_resp_no_accept: got %b want 00", ifb.req_ready); end
        tick();
        n_cmp++; if (ifb.req_ready !== 2'b10) begin n_err++; $display("FAIL lr_next_accept: got %b want 10", ifb.req_ready); end
        tick();
        ifb.req_valid = 2'b00;
        tick();
        tick();
        tick();
    endtask

    // Reset asserted while the RD_DELAY=8 instance waits on read data.
    task automatic test_reset_mid();
        bit ok;
        int bad;
        ifb.req_we         = 2'b00;
        ifb.req_addr[23:0] = 24'h000200;
        ifb.req_valid      = 2'b01;
        #1;
        wait_rdy_b(2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_accept: got no req_ready want req_ready[0] within 40 cycles"); end
        tick();
        ifb.req_valid = 2'b00;
        tick();
        tick();
        gb_rst_n = 1'b0;
        #1;
        n_cmp++; if (ifb.gb_addr !== 24'h0) begin n_err++; $display("FAIL rm_async_addr: got %h want 0", ifb.gb_addr); end
        n_cmp++; if (ifb.gb_rstb !== 1'b0 || ifb.gb_wen !== 1'b0 || ifb.rsp_valid !== 2'b00 || ifb.req_ready !== 2'b00) begin n_err++; $display("FAIL rm_async_ctrl: got rstb=%b wen=%b rsp=%b rdy=%b want all 0", ifb.gb_rstb, ifb.gb_wen, ifb.rsp_valid, ifb.req_ready); end
        n_cmp++; if (ifa.gb_addr !== 24'h0 || ifa.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rm_async_a: got addr=%h rdata=%h want 0/0", ifa.gb_addr, ifa.rsp_rdata); end
        tick();
        tick();
        gb_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (ifb.rsp_valid !== 2'b00 || ifb.gb_rstb !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rm_no_rsp: got %0d cycles with activity want 0", bad); end
        ifb.req_we[1]       = 1'b1;
        ifb.req_addr[47:24] = 24'h000033;
        ifb.req_valid       = 2'b10;
        #1;
        wait_rdy_b(2'b10, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_post_accept: got no req_ready want req_ready[1] within 40 cycles"); end
        tick();
        ifb.req_valid = 2'b00;
        #1;
        n_cmp++; if (ifb.gb_wen !== 1'b1 || ifb.gb_addr !== 24'h000033) begin n_err++; $display("FAIL rm_post_issue: got wen=%b addr=%h want 1/000033", ifb.gb_wen, ifb.gb_addr); end
        tick();
        n_cmp++; if (ifb.rsp_valid !== 2'b10) begin n_err++; $display("FAIL rm_post_rsp: got %b want 10", ifb.rsp_valid); end
        tick();
    endtask

    // Requester 1 raises then drops its request while requester 0 owns the bus.
    task automatic test_drop();
        bit ok;
        int bad;
        ifa.req_we          = 2'b01;
        ifa.req_addr[23:0]  = 24'h000055;
        ifa.req_addr[47:24] = 24'h000BAD;
        ifa.req_valid       = 2'b01;
        #1;
        wait_rdy_a(2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL dr_accept: got no req_ready want req_ready[0] within 40 cycles"); end
        tick();
        ifa.req_valid = 2'b10;
        #1;
        n_cmp++; if (ifa.req_ready !== 2'b00) begin n_err++; $display("FAIL dr_busy_ready: got %b want 00", ifa.req_ready); end
        tick();
        ifa.req_valid = 2'b00;
        #1;
        n_cmp++; if (ifa.rsp_valid !== 2'b01) begin n_err++; $display("FAIL dr_rsp0: got %b want 01", ifa.rsp_valid); end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ifa.req_ready !== 2'b00 || ifa.gb_wen !== 1'b0 || ifa.gb_rstb !== 1'b0 || ifa.rsp_valid !== 2'b00) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL dr_no_grant: got %0d active cycles want 0", bad); end
        n_cmp++; if (ifa.gb_addr !== 24'h000055) begin n_err++; $display("FAIL dr_addr_hold: got %h want 000055", ifa.gb_addr); end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        ifa.req_valid = '0;
        ifa.req_we    = '0;
        ifa.req_addr  = '0;
        ifa.req_wdata = '0;
        ifa.gb_rdata  = '0;
        ifb.req_valid = '0;
        ifb.req_we    = '0;
        ifb.req_addr  = '0;
        ifb.req_wdata = '0;
        ifb.gb_rdata  = '0;
        test_reset();
        test_write();
        test_read();
        test_rr();
        test_long_read();
        test_reset_mid();
        test_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gb_arbiter.md
GB_ARBITER -- requirements
Module: gb_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters (legal 2..4).
REQ-002 Parameter: AW, default 24, ghostbus address width.
REQ-003 Parameter: DW, default 32, ghostbus data width.
REQ-004 Parameter: RD_DELAY, default 1, cycles from read-strobe cycle to valid gb_rdata (legal 1..15).
REQ-005 Port: gb_clk  input  1  sole clock; all logic rising-edge.
REQ-006 Port: gb_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 Port: req_valid  input  NREQ  per-requester transaction request.
REQ-008 Port: req_we  input  NREQ  per-requester 1=write, 0=read.
REQ-009 Port: req_addr  input  NREQ*AW  flattened, requester i at [(i+1)*AW-1 -: AW].
REQ-010 Port: req_wdata  input  NREQ*DW  flattened, same packing.
REQ-011 Port: req_ready  output  NREQ  one-cycle accept pulse, one-hot.
REQ-012 Port: rsp_valid  output  NREQ  one-cycle completion pulse, one-hot.
REQ-013 Port: rsp_rdata  output  DW  read data, shared, qualified by rsp_valid.
REQ-014 Port: gb_addr  output  AW  ghostbus address.
REQ-015 Port: gb_wdata  output  DW  ghostbus write data.
REQ-016 Port: gb_wen  output  1  ghostbus write enable/strobe.
REQ-017 Port: gb_rstb  output  1  ghostbus read strobe.
REQ-018 Port: gb_rdata  input  DW  ghostbus read data.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req_valid, SHALL select winner by round-robin (search starts at last_grant+1, wraps at NREQ-1), pulse req_ready[winner], latch we/addr/wdata/index, update last_grant, go ISSUE; else stay IDLE.
REQ-021 ISSUE: for exactly one cycle SHALL drive latched gb_addr/gb_wdata with gb_wen=we, gb_rstb=~we.
REQ-022 ISSUE write: next state RESP; ISSUE read: load counter with RD_DELAY-1, next state WAIT.
REQ-023 WAIT: decrement counter each cycle; at counter 0 SHALL register gb_rdata into rsp_rdata and go RESP.
REQ-024 RESP: pulse rsp_valid[index] for one cycle, go IDLE; rsp_rdata SHALL be 0 for writes, held until next RESP otherwise.
REQ-025 Latency: write accept-to-rsp_valid 2 cycles; read accept-to-rsp_valid RD_DELAY+2 cycles; gb_rdata sampled exactly RD_DELAY cycles after strobe cycle.
REQ-026 gb_wen and gb_rstb SHALL be 0 outside ISSUE; never both 1.
REQ-027 gb_addr/gb_wdata SHALL hold last issued value outside ISSUE.
REQ-028 At most one transaction outstanding; req_valid ignored outside IDLE.
REQ-029 Requesters hold req_valid/fields stable until req_ready; deasserting earlier drops the request without error.
REQ-030 Simultaneous requests from all requesters SHALL each be granted once in NREQ consecutive grants.
REQ-031 Index/counter arithmetic modulo NREQ and 4 bits respectively; no overflow beyond RD_DELAY≤15.

Reset
REQ-032 On gb_rst_n low: state IDLE, last_grant=NREQ-1 (requester 0 first), counter 0, all outputs 0.
REQ-033 Reset mid-transaction SHALL abort it with no rsp_valid; after release, first accept no earlier than first rising edge with gb_rst_n high.

Structure
REQ-034 Package gb_arb_pkg SHALL hold state encodings (2-bit) and GB_AW=24/GB_DW=32 constants.
REQ-035 Round-robin selection SHALL be sub-module gb_rr_pick (inputs req vector, last_grant; outputs winner index, any).

Verification
REQ-036 Single write, req 0, addr 0x000001, wdata 0xE -> gb_wen one cycle with gb_addr 0x000001, rsp_valid[0] 2 cycles after req_ready[0], rsp_rdata 0.
REQ-037 Read, RD_DELAY=1, req 1, addr 0x000000, gb_rdata=0x42 in cycle after strobe -> rsp_valid[1] with rsp_rdata 0x00000042, 3 cycles after accept.
REQ-038 NREQ=2, both requesting continuously -> grants 0,1,0,1; no requester starved.
REQ-039 RD_DELAY=8 read of 0x000100 -> gb_rstb one cycle, data sampled 8 cycles later, no new accept until rsp_valid.
REQ-040 gb_rst_n asserted during WAIT -> outputs 0 asynchronously, no rsp_valid; next request accepted normally after release.
REQ-041 Requester drops req_valid before accept while other busy -> no grant, no bus strobe for it.
